// File: rtl/hdmi_pkg.sv
// Shared types and helpers for the HDMI video source switch.
package hdmi_pkg;

    // Switch controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        MUTE    = 2'd2
    } state_e;

    // Width of the mute frame counter
    localparam int unsigned FRM_W = 4;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 32'd1) begin
            return 32'd1;
        end
        return $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/hdmi_vs_edge.sv
// Registered vsync with a polarity-aware leading-edge pulse.
module hdmi_vs_edge
    import hdmi_pkg::*;
#(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic vs_i,
    input  logic mask_i,
    output logic lead_c_o
);

    logic vs_q;

    // Previous vsync sample, reset to the inactive level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q <= ~SYNC_POL;
        end else begin
            vs_q <= vs_i;
        end
    end

    // Inactive -> active transition; masked while vs_q still holds another source
    assign lead_c_o = (vs_i == SYNC_POL) && (vs_q != SYNC_POL) && !mask_i;

endmodule

// File: rtl/hdmi_video_switch.sv
// N-source video selector that switches on a vsync boundary and mutes
// the output for a number of frames after each switch.
module hdmi_video_switch
    import hdmi_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned RGB_W       = 24,
    parameter int unsigned SEL_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned MUTE_FRAMES = 2,
    parameter int unsigned VS_TIMEOUT  = 1048576
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC*RGB_W-1:0]   src_rgb,
    input  logic [NUM_SRC-1:0]         src_hs,
    input  logic [NUM_SRC-1:0]         src_vs,
    input  logic [NUM_SRC-1:0]         src_de,
    input  logic [SEL_W-1:0]           sel_req,
    output logic [RGB_W-1:0]           out_rgb,
    output logic                       out_hs,
    output logic                       out_vs,
    output logic                       out_de,
    output logic                       out_blank,
    output logic [SEL_W-1:0]           sel_cur,
    output logic                       switching
);

    localparam int unsigned TO_W = cnt_width(VS_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(VS_TIMEOUT - 32'd1);
    localparam logic [TO_W-1:0]  TO_MAX  = {TO_W{1'b1}};
    localparam logic [FRM_W-1:0] FRM_END = FRM_W'(MUTE_FRAMES);

    // Stage 1 registers
    logic [RGB_W-1:0]   s1_rgb_q [NUM_SRC];
    logic [NUM_SRC-1:0] s1_hs_q;
    logic [NUM_SRC-1:0] s1_vs_q;
    logic [NUM_SRC-1:0] s1_de_q;

    // Selected-source view of stage 1
    logic [RGB_W-1:0] sel_rgb_c;
    logic             sel_hs_c;
    logic             sel_vs_c;
    logic             sel_de_c;

    // Controller state
    state_e           state_q,     state_d;
    logic [SEL_W-1:0] tgt_q,       tgt_d;
    logic [SEL_W-1:0] sel_cur_q,   sel_cur_d;
    logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
    logic [FRM_W-1:0] frm_cnt_q,   frm_cnt_d;
    logic             sel_chg_q,   sel_chg_d;
    logic             switching_q, switching_d;

    logic lead_c;
    logic req_ok_c;
    logic pass_c;

    // Stage 2 output registers
    logic [RGB_W-1:0] out_rgb_q;
    logic             out_hs_q;
    logic             out_vs_q;
    logic             out_de_q;
    logic             out_blank_q;

    // Capture every source unconditionally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                s1_rgb_q[i] <= '0;
            end
            s1_hs_q <= {NUM_SRC{~SYNC_POL}};
            s1_vs_q <= {NUM_SRC{~SYNC_POL}};
            s1_de_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                s1_rgb_q[i] <= src_rgb[i*RGB_W +: RGB_W];
            end
            s1_hs_q <= src_hs;
            s1_vs_q <= src_vs;
            s1_de_q <= src_de;
        end
    end

    // Route the currently selected source out of stage 1
    always_comb begin
        sel_rgb_c = '0;
        sel_hs_c  = ~SYNC_POL;
        sel_vs_c  = ~SYNC_POL;
        sel_de_c  = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (sel_cur_q == SEL_W'(i)) begin
                sel_rgb_c = s1_rgb_q[i];
                sel_hs_c  = s1_hs_q[i];
                sel_vs_c  = s1_vs_q[i];
                sel_de_c  = s1_de_q[i];
            end
        end
    end

    // Vsync leading edge of the selected source
    hdmi_vs_edge #(
        .SYNC_POL (SYNC_POL)
    ) u_vs_edge (
        .clk      (clk),
        .reset    (reset),
        .vs_i     (sel_vs_c),
        .mask_i   (sel_chg_q),
        .lead_c_o (lead_c)
    );

    // A request is actionable only if it names a different, existing source
    assign req_ok_c = (sel_req != sel_cur_q) && (32'(sel_req) < NUM_SRC);

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            sel_cur_q   <= '0;
            to_cnt_q    <= '0;
            frm_cnt_q   <= '0;
            sel_chg_q   <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            sel_cur_q   <= sel_cur_d;
            to_cnt_q    <= to_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
            sel_chg_q   <= sel_chg_d;
            switching_q <= switching_d;
        end
    end

    // Controller next-state logic
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        sel_cur_d = sel_cur_q;
        to_cnt_d  = to_cnt_q;
        frm_cnt_d = frm_cnt_q;
        sel_chg_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_ok_c) begin
                    tgt_d    = sel_req;
                    to_cnt_d = '0;
                    state_d  = WAIT_VS;
                end
            end
            WAIT_VS: begin
                // Edge and timeout together still give a single switch
                if (lead_c || (to_cnt_q == TO_LAST)) begin
                    sel_cur_d = tgt_q;
                    frm_cnt_d = '0;
                    sel_chg_d = 1'b1;
                    state_d   = MUTE;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            MUTE: begin
                // No timeout here: a dead new source keeps the output muted
                if (lead_c) begin
                    frm_cnt_d = frm_cnt_q + FRM_W'(1);
                    if ((frm_cnt_q + FRM_W'(1)) == FRM_END) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        switching_d = (state_d != IDLE);
    end

    // Pixels pass only with data enable and outside the mute window
    assign pass_c = sel_de_c && (state_q != MUTE);

    // Stage 2: blank and register the outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_rgb_q   <= '0;
            out_hs_q    <= ~SYNC_POL;
            out_vs_q    <= ~SYNC_POL;
            out_de_q    <= 1'b0;
            out_blank_q <= 1'b1;
        end else begin
            out_rgb_q   <= pass_c ? sel_rgb_c : '0;
            out_hs_q    <= sel_hs_c;
            out_vs_q    <= sel_vs_c;
            out_de_q    <= sel_de_c;
            out_blank_q <= ~pass_c;
        end
    end

    assign out_rgb   = out_rgb_q;
    assign out_hs    = out_hs_q;
    assign out_vs    = out_vs_q;
    assign out_de    = out_de_q;
    assign out_blank = out_blank_q;
    assign sel_cur   = sel_cur_q;
    assign switching = switching_q;

endmodule
